s8254_bus_master: RTL
=====================

S8254_BUS_MASTER -- requirements
Module: s8254_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1, cycles CS_N/a/id are valid before the strobe falls (range 1-15).
REQ-002 Parameter STROBE_CYC, default 2, cycles IOR_N/IOW_N are held low (range 1-15).
REQ-003 Parameter HOLD_CYC, default 1, cycles CS_N/a/id are held after the strobe rises (range 1-15).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts a request; high only in IDLE.
REQ-008 op  input  2  00 WRITE, 01 READ, 10 PROGRAM, 11 LATCH_READ.
REQ-009 addr  input  2  port address; used by WRITE/READ only.
REQ-010 wdata  input  8  byte to write; WRITE only.
REQ-011 mode  input  6  {RW1,RW0,M2,M1,M0,BCD}; used by PROGRAM/LATCH_READ.
REQ-012 count  input  16  initial count; PROGRAM only.
REQ-013 rsp_valid  output  1  one-cycle pulse at request completion.
REQ-014 rsp_data  output  16  assembled read data; zero for write-only ops.
REQ-015 busy  output  1  transaction in progress.
REQ-016 CS_N  output  1  chip select to timer, active low.
REQ-017 a  output  2  timer address.
REQ-018 id  output  8  data to timer.
REQ-019 od  input  8  data from timer.
REQ-020 IOR_N / IOW_N  output  1 each  read / write strobes, active low.

Function
REQ-021 Handshake: request accepted on the rising edge with req_valid & req_ready; all request inputs captured then; later input changes ignored.
REQ-022 At acceptance, a byte list of 1-3 entries {dir,a,data} is built:
- WRITE: {W,addr,wdata}.
- READ: {R,addr}.
- PROGRAM: {W,11,{00,mode}}, then by RW: 01 {W,00,count[7:0]}; 10 {W,00,count[15:8]}; 11 LSB then MSB; 00 control word only.
- LATCH_READ: {W,11,8'h00}, then by RW: 01 one read; 10 one read; 11 two reads (LSB, then MSB); 00 no reads.
REQ-023 FSM states IDLE, SETUP, STROBE, HOLD, GAP:
- IDLE→SETUP on accept.
- SETUP→STROBE after SETUP_CYC cycles.
- STROBE→HOLD after STROBE_CYC cycles.
- HOLD→GAP after HOLD_CYC cycles.
- GAP (1 cycle)→SETUP if entries remain, else →IDLE with rsp_valid.
REQ-024 CS_N is low in SETUP, STROBE and HOLD, and high in IDLE and GAP; every byte is therefore a distinct chip-select cycle.
REQ-025 a and id are stable from the first SETUP cycle through the last HOLD cycle of each byte; id = 0 for read bytes and in IDLE.
REQ-026 IOW_N (write byte) or IOR_N (read byte) is low only in STROBE; both strobes are never low in the same cycle.
REQ-027 od is sampled on the rising edge that ends the last STROBE cycle.
REQ-028 Read assembly:
- RW=01: rsp_data={8'h00,b0}.
- RW=10: rsp_data={b0,8'h00}.
- RW=11: rsp_data={b1,b0}.
- READ op: rsp_data={8'h00,b0}.
REQ-029 rsp_data holds its value until the next rsp_valid.
REQ-030 Per-byte latency = SETUP_CYC+STROBE_CYC+HOLD_CYC+1; rsp_valid asserts in the cycle after the last GAP. With defaults, a 3-byte PROGRAM accepted at cycle 0 gives rsp_valid at cycle 16.
REQ-031 busy = !req_ready.
REQ-032 A request is never accepted while busy, including in the rsp_valid cycle.

Reset
REQ-033 While rst is high, on the next edge: FSM→IDLE, CS_N=1, IOR_N=1, IOW_N=1, a=00, id=00, rsp_valid=0, rsp_data=0, req_ready=1, busy=0.
REQ-034 Reset asserted mid-transaction abandons it with no rsp_valid; strobes rise on that same edge.

Structure
REQ-035 A shared package holds the op encodings, the port address constants (CNT0=00, CTRL=11), the latch command 8'h00, and the FSM state typedef.
REQ-036 One sub-module, s8254_bus_cycle, implements a single SETUP/STROBE/HOLD/GAP byte cycle (start, dir, a, data in; done, rdata out); the top module sequences the byte list.

Verification
REQ-037 PROGRAM, mode=6'b110110, count=16'h1234 → three write cycles: a=11 id=36; a=00 id=34; a=00 id=12. IOW_N low 2 cycles each; rsp_valid at cycle 16.
REQ-038 LATCH_READ, RW=11, timer model returns 8'hCD then 8'hAB → one write a=11 id=00, two reads a=00, rsp_data=16'hABCD.
REQ-039 READ addr=00 with od=8'h5A → rsp_data=16'h005A; IOR_N low exactly STROBE_CYC cycles; IOW_N never low.
REQ-040 req_valid held high back-to-back → second request accepted only after rsp_valid; CS_N high at least 1 cycle between bytes.
REQ-041 rst in second STROBE cycle of a PROGRAM → next edge: all strobes and CS_N high, no rsp_valid, req_ready=1.
REQ-042 Bus monitor on all tests: a and id never change while CS_N is low; IOR_N and IOW_N are never both low.

Source files
------------

// File: rtl/s8254_bus_master_pkg.sv
// Shared encodings, bus-cycle state type and byte-list helpers for the 8254 bus master.
package s8254_bus_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ       = 2'b01,
    OP_PROGRAM    = 2'b10,
    OP_LATCH_READ = 2'b11
  } op_e;

  localparam logic [1:0] ADDR_CNT0 = 2'b00;
  localparam logic [1:0] ADDR_CTRL = 2'b11;
  localparam logic [7:0] LATCH_CMD = 8'h00;
  localparam logic       DIR_W     = 1'b0;
  localparam logic       DIR_R     = 1'b1;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP} bus_state_e;

  typedef struct packed {
    logic       dir;
    logic [1:0] a;
    logic [7:0] data;
  } bus_byte_t;

  typedef struct packed {
    bus_byte_t [2:0] ent;
    logic [1:0]      len;
  } byte_list_t;

  // Expands one request into the 1-3 chip-select cycles it needs on the timer bus.
  function automatic byte_list_t build_list(input op_e op, input logic [1:0] addr,
                                            input logic [7:0] wdata, input logic [5:0] mode,
                                            input logic [15:0] count);
    byte_list_t l;
    l     = '0;
    l.len = 2'd1;
    case (op)
      OP_WRITE: l.ent[0] = {DIR_W, addr, wdata};
      OP_READ:  l.ent[0] = {DIR_R, addr, 8'h00};
      OP_PROGRAM: begin
        l.ent[0] = {DIR_W, ADDR_CTRL, {2'b00, mode}};
        case (mode[5:4])
          2'b01: begin l.ent[1] = {DIR_W, ADDR_CNT0, count[7:0]};  l.len = 2'd2; end
          2'b10: begin l.ent[1] = {DIR_W, ADDR_CNT0, count[15:8]}; l.len = 2'd2; end
          2'b11: begin
            l.ent[1] = {DIR_W, ADDR_CNT0, count[7:0]};
            l.ent[2] = {DIR_W, ADDR_CNT0, count[15:8]};
            l.len    = 2'd3;
          end
          default: l.len = 2'd1;
        endcase
      end
      OP_LATCH_READ: begin
        l.ent[0] = {DIR_W, ADDR_CTRL, LATCH_CMD};
        case (mode[5:4])
          2'b01, 2'b10: begin l.ent[1] = {DIR_R, ADDR_CNT0, 8'h00}; l.len = 2'd2; end
          2'b11: begin
            l.ent[1] = {DIR_R, ADDR_CNT0, 8'h00};
            l.ent[2] = {DIR_R, ADDR_CNT0, 8'h00};
            l.len    = 2'd3;
          end
          default: l.len = 2'd1;
        endcase
      end
      default: l.len = 2'd1;
    endcase
    return l;
  endfunction

  function automatic logic [15:0] assemble(input op_e op, input logic [1:0] rw,
                                           input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] d;
    d = 16'h0000;
    if (op == OP_READ) begin
      d = {8'h00, b0};
    end else if (op == OP_LATCH_READ) begin
      case (rw)
        2'b01:   d = {8'h00, b0};
        2'b10:   d = {b0, 8'h00};
        2'b11:   d = {b1, b0};
        default: d = 16'h0000;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/s8254_bus_cycle.sv
// One timer-bus byte cycle: SETUP, STROBE, HOLD with chip select low, then a one-cycle GAP.
module s8254_bus_cycle
  import s8254_bus_master_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_dir,
  input  logic [1:0] i_a,
  input  logic [7:0] i_data,
  input  logic [7:0] i_od,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_cs_n,
  output logic       o_ior_n,
  output logic       o_iow_n,
  output logic [1:0] o_a,
  output logic [7:0] o_id
);

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

  bus_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_dir;
  logic [1:0] r_a;
  logic [7:0] r_data;
  logic [7:0] r_rdata;
  logic       w_cs;

  always_comb begin
    // NOTE: every comb output gets a default up front, so no branch can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 4'd1;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_start) w_state_nxt = ST_SETUP;
      end
      ST_SETUP:  if (r_cnt == SETUP_LAST)  begin w_state_nxt = ST_STROBE; w_cnt_nxt = '0; end
      ST_STROBE: if (r_cnt == STROBE_LAST) begin w_state_nxt = ST_HOLD;   w_cnt_nxt = '0; end
      ST_HOLD:   if (r_cnt == HOLD_LAST)   begin w_state_nxt = ST_GAP;    w_cnt_nxt = '0; end
      ST_GAP: begin
        w_cnt_nxt   = '0;
        w_state_nxt = i_start ? ST_SETUP : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment only, so every register sees pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_W;
      r_a     <= '0;
      r_data  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_start && (r_state == ST_IDLE || r_state == ST_GAP)) begin
        r_dir  <= i_dir;
        r_a    <= i_a;
        r_data <= i_data;
      end
      // Read data is captured on the edge that ends the final strobe cycle.
      if (r_state == ST_STROBE && r_cnt == STROBE_LAST) r_rdata <= i_od;
    end
  end

  assign w_cs    = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
  assign o_cs_n  = !w_cs;
  assign o_iow_n = !(r_state == ST_STROBE && r_dir == DIR_W);
  assign o_ior_n = !(r_state == ST_STROBE && r_dir == DIR_R);
  assign o_a     = w_cs ? r_a : 2'b00;
  assign o_id    = (w_cs && r_dir == DIR_W) ? r_data : 8'h00;
  assign o_done  = (r_state == ST_GAP);
  assign o_rdata = r_rdata;

endmodule

// File: rtl/s8254_bus_master.sv
// Request-level front end: captures a request, walks its byte list through the bus cycle, assembles reads.
module s8254_bus_master
  import s8254_bus_master_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  input  logic [5:0]  mode,
  input  logic [15:0] count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        CS_N,
  output logic [1:0]  a,
  output logic [7:0]  id,
  input  logic [7:0]  od,
  output logic        IOR_N,
  output logic        IOW_N
);

  logic        r_busy;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  byte_list_t  r_list;
  logic [1:0]  r_idx;
  op_e         r_op;
  logic [1:0]  r_rw;
  logic        r_rd_cnt;
  logic [7:0]  r_b0, r_b1;
  logic        r_cur_dir;

  byte_list_t  w_list;
  bus_byte_t   w_start_ent;
  logic        w_accept, w_start, w_done, w_more, w_last, w_rd_byte;
  logic [7:0]  w_rdata, w_b0, w_b1;

  assign req_ready = !r_busy && !r_rsp_valid;
  assign busy      = !req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  assign w_list    = build_list(op_e'(op), addr, wdata, mode, count);
  assign w_accept  = req_valid && req_ready;
  // r_idx points at the next entry to launch; the list is done once it reaches len.
  assign w_more    = (r_idx != r_list.len);
  assign w_start   = w_accept || (w_done && w_more);
  assign w_last    = w_done && !w_more;
  assign w_rd_byte = w_done && (r_cur_dir == DIR_R);
  assign w_b0      = (w_rd_byte && !r_rd_cnt) ? w_rdata : r_b0;
  assign w_b1      = (w_rd_byte && r_rd_cnt)  ? w_rdata : r_b1;

  // The first byte launches straight from the incoming request so no cycle is lost.
  always_comb begin
    case (r_idx)
      2'd1:    w_start_ent = r_list.ent[1];
      2'd2:    w_start_ent = r_list.ent[2];
      default: w_start_ent = r_list.ent[0];
    endcase
    if (w_accept) w_start_ent = w_list.ent[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_list      <= '0;
      r_idx       <= '0;
      r_op        <= OP_WRITE;
      r_rw        <= '0;
      r_rd_cnt    <= 1'b0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_cur_dir   <= DIR_W;
    end else begin
      r_rsp_valid <= w_last;
      if (w_start) r_cur_dir <= w_start_ent.dir;
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_list   <= w_list;
        r_idx    <= 2'd1;
        r_op     <= op_e'(op);
        r_rw     <= mode[5:4];
        r_rd_cnt <= 1'b0;
        r_b0     <= '0;
        r_b1     <= '0;
      end else begin
        if (w_done && w_more) r_idx <= r_idx + 2'd1;
        if (w_rd_byte) begin
          r_b0     <= w_b0;
          r_b1     <= w_b1;
          r_rd_cnt <= 1'b1;
        end
        if (w_last) begin
          r_busy     <= 1'b0;
          r_rsp_data <= assemble(r_op, r_rw, w_b0, w_b1);
        end
      end
    end
  end

  s8254_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cycle (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_dir  (w_start_ent.dir),
    .i_a    (w_start_ent.a),
    .i_data (w_start_ent.data),
    .i_od   (od),
    .o_done (w_done),
    .o_rdata(w_rdata),
    .o_cs_n (CS_N),
    .o_ior_n(IOR_N),
    .o_iow_n(IOW_N),
    .o_a    (a),
    .o_id   (id)
  );

endmodule
